// File: rtl/alu_seq_if.sv
// Control-strobe bundle between the sequencer (master) and the single-bus datapath (slave).
interface alu_seq_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned OP_W = 5;

  logic [DATA_W-1:0] IR;
  logic              Stop;

  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic IncPC, Read;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [OP_W-1:0] opcode;
  logic Run;

  modport master (
    input  IR, Stop,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, Gra, Grb, Grc, Rin, Rout, opcode, Run
  );

  modport slave (
    output IR, Stop,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, opcode, Run
  );
endinterface

// File: rtl/alu_sequencer.sv
// Hardwired Moore control unit: fetch plus execute of ALU-class instructions.
module alu_sequencer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic       Clock,
  input  logic       clear,
  alu_seq_if.master  bus
);
  localparam int unsigned OP_W  = 5;
  localparam int unsigned OP_HI = DATA_W - 1;

  typedef enum logic [3:0] {
    RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0] op;
  logic is_rfmt, is_imm, is_muldiv, is_unary, is_halt, is_nop;
  logic last_d;

  assign op = bus.IR[OP_HI -: OP_W];

  // Field bits below the opcode only steer the datapath's register file.
  logic unused_fields;
  assign unused_fields = ^bus.IR[OP_HI-OP_W:0];

  // Instruction class decode; anything unrecognised behaves as nop.
  always_comb begin
    is_rfmt   = (op >= 5'b00011) && (op <= 5'b01011);
    is_imm    = (op >= 5'b01100) && (op <= 5'b01110);
    is_muldiv = (op == 5'b01111) || (op == 5'b10000);
    is_unary  = (op == 5'b10001) || (op == 5'b10010);
    is_halt   = (op == 5'b11011);
    is_nop    = !(is_rfmt || is_imm || is_muldiv || is_unary || is_halt);
  end

  // State register with synchronous clear.
  always_ff @(posedge Clock) begin
    if (clear) state_q <= RESET_ST;
    else       state_q <= state_d;
  end

  // Next-state logic; Stop only matters in an instruction's last state.
  always_comb begin
    state_d = state_q;
    last_d  = bus.Stop ? 1'b1 : 1'b0;
    unique case (state_q)
      RESET_ST: state_d = T0;
      T0:       state_d = T1;
      T1:       state_d = T2;
      T2:       state_d = T3;
      T3: begin
        if (is_halt)     state_d = HALT;
        else if (is_nop) state_d = last_d ? HALT : T0;
        else             state_d = T4;
      end
      T4: begin
        if (is_unary) state_d = last_d ? HALT : T0;
        else          state_d = T5;
      end
      T5: begin
        if (is_muldiv) state_d = T6;
        else           state_d = last_d ? HALT : T0;
      end
      T6:       state_d = last_d ? HALT : T0;
      HALT:     state_d = HALT;
      default:  state_d = RESET_ST;
    endcase
  end

  // Strobe decode from the current state and IR.
  always_comb begin
    bus.PCout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.Cout = 1'b0;
    bus.PCin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
    bus.IncPC = 1'b0; bus.Read = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.opcode = OP_W'(0);
    bus.Run = (state_q != RESET_ST) && (state_q != HALT);
    unique case (state_q)
      T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      T3: begin
        if (is_rfmt || is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_unary) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
        end
      end
      T4: begin
        if (is_rfmt) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
        end else if (is_imm) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
        end else if (is_muldiv) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
        end else if (is_unary) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      T5: begin
        if (is_muldiv) begin
          bus.Zlowout = 1'b1; bus.LOin = 1'b1;
        end else if (is_rfmt || is_imm) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      T6: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
      end
      default: ;
    endcase
  end

  // Single driver on the shared bus.
  a_one_source: assert property (@(posedge Clock) disable iff (clear)
    $onehot0({bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout, bus.Cout}));

  // ALU opcode only accompanies a real Z load.
  a_opcode_zin: assert property (@(posedge Clock) disable iff (clear)
    (bus.opcode != OP_W'(0)) |-> (bus.Zin && (state_q != T0)));
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: stimulus queues the expected strobe word per cycle, a monitor compares.
module tb_alu_sequencer;
  logic Clock;
  logic clear;

  alu_seq_if #(.DATA_W(32)) bus ();

  alu_sequencer #(.DATA_W(32)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Strobe word layout (MSB..LSB)
  localparam logic [27:0] RUN   = 28'(1) << 27;
  localparam logic [27:0] PCOUT = 28'(1) << 26;
  localparam logic [27:0] ZHOUT = 28'(1) << 25;
  localparam logic [27:0] ZLOUT = 28'(1) << 24;
  localparam logic [27:0] MDROUT= 28'(1) << 23;
  localparam logic [27:0] COUT  = 28'(1) << 20;
  localparam logic [27:0] PCIN  = 28'(1) << 19;
  localparam logic [27:0] MARIN = 28'(1) << 18;
  localparam logic [27:0] MDRIN = 28'(1) << 17;
  localparam logic [27:0] IRIN  = 28'(1) << 16;
  localparam logic [27:0] YIN   = 28'(1) << 15;
  localparam logic [27:0] ZIN   = 28'(1) << 14;
  localparam logic [27:0] HIIN  = 28'(1) << 13;
  localparam logic [27:0] LOIN  = 28'(1) << 12;
  localparam logic [27:0] INCPC = 28'(1) << 11;
  localparam logic [27:0] READ  = 28'(1) << 10;
  localparam logic [27:0] GRA   = 28'(1) << 9;
  localparam logic [27:0] GRB   = 28'(1) << 8;
  localparam logic [27:0] GRC   = 28'(1) << 7;
  localparam logic [27:0] RIN   = 28'(1) << 6;
  localparam logic [27:0] ROUT  = 28'(1) << 5;

  localparam logic [27:0] E_T0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [27:0] E_T1 = RUN | ZLOUT | PCIN | READ | MDRIN;
  localparam logic [27:0] E_T2 = RUN | MDROUT | IRIN;

  localparam logic [31:0] IR_SHL  = 32'h4A918000;
  localparam logic [31:0] IR_MUL  = 32'h7A080000;
  localparam logic [31:0] IR_ADDI = 32'h6209FFFF;
  localparam logic [31:0] IR_NEG  = 32'h88900000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_UNK  = 32'hF8000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_DIV  = 32'h80880000;

  logic [27:0] exp_q [$];
  string       tag_q [$];
  int          checks;
  int          errors;

  function automatic logic [27:0] actual();
    return {bus.Run, bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout,
            bus.LOout, bus.Cout, bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin,
            bus.Zin, bus.HIin, bus.LOin, bus.IncPC, bus.Read, bus.Gra, bus.Grb,
            bus.Grc, bus.Rin, bus.Rout, bus.opcode};
  endfunction

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge Clock) begin
    logic [27:0] e;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (actual() !== e) begin
        errors++;
        $display("FAIL %s: strobes act=%07h exp=%07h", t, actual(), e);
      end
    end
  end

  // One clock cycle: drive inputs for this cycle and queue the expected strobes.
  task automatic cyc(input logic clr, input logic stp, input logic [31:0] ir,
                     input logic [27:0] e, input string tag);
    @(posedge Clock);
    #1;
    clear  = clr;
    bus.Stop = stp;
    bus.IR = ir;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic fetch(input logic [31:0] ir, input string name);
    cyc(1'b0, 1'b0, ir, E_T0, {name, "_t0"});
    cyc(1'b0, 1'b0, ir, E_T1, {name, "_t1"});
    cyc(1'b0, 1'b0, ir, E_T2, {name, "_t2"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    bus.Stop = 1'b0;
    bus.IR = 32'h0;

    // Reset held, then released into shl
    cyc(1'b1, 1'b0, IR_SHL, 28'h0, "rst_hold");
    cyc(1'b0, 1'b0, IR_SHL, 28'h0, "rst_release");
    fetch(IR_SHL, "shl");
    cyc(1'b0, 1'b0, IR_SHL, RUN | GRB | ROUT | YIN, "shl_t3");
    cyc(1'b0, 1'b0, IR_SHL, RUN | GRC | ROUT | ZIN | 28'(5'b01001), "shl_t4");
    cyc(1'b0, 1'b0, IR_SHL, RUN | ZLOUT | GRA | RIN, "shl_t5");

    // mul: 7-cycle sequence
    fetch(IR_MUL, "mul");
    cyc(1'b0, 1'b0, IR_MUL, RUN | GRA | ROUT | YIN, "mul_t3");
    cyc(1'b0, 1'b0, IR_MUL, RUN | GRB | ROUT | ZIN | 28'(5'b01111), "mul_t4");
    cyc(1'b0, 1'b0, IR_MUL, RUN | ZLOUT | LOIN, "mul_t5");
    cyc(1'b0, 1'b0, IR_MUL, RUN | ZHOUT | HIIN, "mul_t6");

    // addi: constant onto the bus, no register read in T4
    fetch(IR_ADDI, "addi");
    cyc(1'b0, 1'b0, IR_ADDI, RUN | GRB | ROUT | YIN, "addi_t3");
    cyc(1'b0, 1'b0, IR_ADDI, RUN | COUT | ZIN | 28'(5'b01100), "addi_t4");
    cyc(1'b0, 1'b0, IR_ADDI, RUN | ZLOUT | GRA | RIN, "addi_t5");

    // neg: 5-cycle unary
    fetch(IR_NEG, "neg");
    cyc(1'b0, 1'b0, IR_NEG, RUN | GRB | ROUT | ZIN | 28'(5'b10001), "neg_t3");
    cyc(1'b0, 1'b0, IR_NEG, RUN | ZLOUT | GRA | RIN, "neg_t4");

    // nop and unrecognised op both take 4 cycles
    fetch(IR_NOP, "nop");
    cyc(1'b0, 1'b0, IR_NOP, RUN, "nop_t3");
    fetch(IR_UNK, "unk");
    cyc(1'b0, 1'b0, IR_UNK, RUN, "unk_t3");

    // halt: parks with everything low until clear
    fetch(IR_HALT, "halt");
    cyc(1'b0, 1'b0, IR_HALT, RUN, "halt_t3");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, IR_HALT, 28'h0, "halt_idle");
    cyc(1'b1, 1'b0, IR_HALT, 28'h0, "halt_clear");
    cyc(1'b0, 1'b0, IR_HALT, 28'h0, "halt_rst");

    // add with Stop: ignored in T4, honoured in T5
    fetch(IR_ADD, "add");
    cyc(1'b0, 1'b0, IR_ADD, RUN | GRB | ROUT | YIN, "add_t3");
    cyc(1'b0, 1'b1, IR_ADD, RUN | GRC | ROUT | ZIN | 28'(5'b00011), "add_t4_stop");
    cyc(1'b0, 1'b1, IR_ADD, RUN | ZLOUT | GRA | RIN, "add_t5_stop");
    cyc(1'b0, 1'b1, IR_ADD, 28'h0, "add_halt");
    cyc(1'b0, 1'b0, IR_ADD, 28'h0, "add_halt2");
    cyc(1'b1, 1'b0, IR_ADD, 28'h0, "add_clear");
    cyc(1'b0, 1'b0, IR_ADD, 28'h0, "add_rst");

    // div aborted by clear in T4: no LOin/HIin, fetch restarts
    fetch(IR_DIV, "div");
    cyc(1'b0, 1'b0, IR_DIV, RUN | GRA | ROUT | YIN, "div_t3");
    cyc(1'b1, 1'b0, IR_DIV, RUN | GRB | ROUT | ZIN | 28'(5'b10000), "div_t4_clear");
    cyc(1'b0, 1'b0, IR_DIV, 28'h0, "div_rst");
    fetch(IR_DIV, "div2");
    cyc(1'b0, 1'b0, IR_DIV, RUN | GRA | ROUT | YIN, "div2_t3");
    cyc(1'b0, 1'b0, IR_DIV, RUN | GRB | ROUT | ZIN | 28'(5'b10000), "div2_t4");
    cyc(1'b0, 1'b0, IR_DIV, RUN | ZLOUT | LOIN, "div2_t5");
    cyc(1'b0, 1'b1, IR_DIV, RUN | ZHOUT | HIIN, "div2_t6_stop");
    cyc(1'b0, 1'b0, IR_DIV, 28'h0, "div2_halt");

    // Let the monitor drain, bounded
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge Clock);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Hardwired control unit that sequences the single-bus datapath through instruction fetch and execute for ALU-class instructions. These are register-register, immediate, unary, multiply/divide, nop and halt.
- Drives every datapath strobe: register-file select, bus-source enables, register load enables, memory read and the 5-bit ALU opcode.
- Replaces hand-sequenced T0..T5 stimulus, so that a complete CPU can run instructions directly from memory.

Parameters:
- DATA_W, 32, instruction/IR width; not intended to change.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; synchronous, active-high.
- IR  in  32  instruction register contents. Fields: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc.
- Stop  in  1  external halt request.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout  out  1 each  bus-source enables.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment and memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select and enables.
- opcode  out  5  ALU operation select.
- Run  out  1  high while executing; low in RESET_ST and HALT.

Behaviour:
- Architecture:
  - Moore machine with registered state.
  - All outputs are a pure decode of the state register and IR.
  - Each state lasts exactly one Clock cycle.
  - Outputs not listed for a state are 0; opcode is 5'b00000 unless listed.
- Opcodes:
  - add 00011, sub 00100, and 00101, or 00110.
  - shr 00111, shra 01000, shl 01001, ror 01010, rol 01011.
  - addi 01100, andi 01101, ori 01110.
  - mul 01111, div 10000, neg 10001, not 10010.
  - nop 11010, halt 11011.
  - Any other op is treated as nop.
- States: RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT.
- clear:
  - While clear is sampled 1, next state is RESET_ST from any state, including mid-instruction.
  - In RESET_ST all outputs and Run are 0.
  - RESET_ST goes to T0 on the first edge with clear = 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Memory is single-cycle, so data is valid on the same edge.
  - T2: MDRout, IRin.
  - IR is valid from T3 onward.
- T3, decoded on IR[31:27]:
  - R-format (add..rol), immediates and mul/div: Grb, Rout, Yin for all but mul/div; mul/div use Gra, Rout, Yin.
  - neg/not: Grb, Rout, Zin, opcode = op; next state T4.
  - nop: no strobes; next state T0, or HALT if Stop.
  - halt: next state HALT.
- T4:
  - R-format: Grc, Rout, Zin, opcode = op.
  - Immediate: Cout, Zin, opcode = op.
  - mul/div: Grb, Rout, Zin, opcode = op.
  - neg/not: Zlowout, Gra, Rin; last state.
- T5:
  - R-format and immediate: Zlowout, Gra, Rin; last state.
  - mul/div: Zlowout, LOin; next state T6.
- T6: Zhighout, HIin; last state.
- Last state of any instruction: next state is T0 if Stop = 0, else HALT. Stop is ignored in all other states.
- HALT: all strobes 0, Run = 0; the only exit is clear.
- Instruction length including fetch:
  - 4 cycles: nop.
  - 5 cycles: neg/not.
  - 6 cycles: R-format and immediate.
  - 7 cycles: mul/div.
- Assertions:
  - At most one bus-source enable is high in any cycle.
  - opcode is nonzero only when Zin is high outside T0.

Test Plan:
1. clear held 2 cycles, then released with IR = 0x4A918000 (shl R5, R2, R3) -> RESET_ST, T0..T5. Required strobes:
   - T3: Grb, Rout, Yin.
   - T4: Grc, Rout, Zin, opcode = 01001.
   - T5: Zlowout, Gra, Rin.
   - Then T0 again; Run = 1 throughout.
2. IR = 0x7A080000 (mul R4, R1) -> 7-cycle sequence. T5 asserts Zlowout+LOin, T6 asserts Zhighout+HIin, then T0.
3. IR = 0x6209FFFF (addi R4, R1, -1) -> T4 asserts Cout, Zin, opcode = 01100, with Rout = 0.
4. IR = 0xD8000000 (halt) -> HALT entered after T3; Run = 0 and all outputs 0 for 10 cycles. clear then returns the machine to RESET_ST and T0.
5. Stop pulsed during T4 of an add, then held 1 through T5 -> Stop in T4 is ignored; Stop in T5 sends the machine to HALT instead of T0.
6. clear asserted during T4 of div -> next state RESET_ST with all strobes 0. No HIin or LOin pulse occurs, and fetch restarts at T0.
